// File: rtl/posit_regime_run_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : posit_regime_run_pipe
//  Purpose  : Two-stage pipelined regime-run counter for SIMD posit words.
//             The word is split into lanes of MIN_LANE << mode bits. Each
//             lane reports its regime run length, regime bit and a flag for
//             a run that reaches the lane LSB.
//  Revision : 1.0  initial release
// ============================================================================
module posit_regime_run_pipe #(
    parameter  int W        = 32,
    parameter  int MIN_LANE = 8,
    localparam int NL       = W / MIN_LANE,
    localparam int CW       = $clog2(W),
    localparam int MAXM     = $clog2(NL),
    localparam int MODE_W   = ($clog2(MAXM + 1) < 1) ? 1 : $clog2(MAXM + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic [MODE_W-1:0]    in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NL*CW-1:0]     out_run,
    output logic [NL-1:0]        out_rbit,
    output logic [NL-1:0]        out_term,
    output logic [MODE_W-1:0]    out_mode
);

    localparam logic [MODE_W-1:0] c_MAX_MODE = MODE_W'(MAXM);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_s2_adv;
    logic w_s1_adv;
    logic r_s1_valid;

    assign w_s2_adv = !out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    // ------------------------------------------------------------------
    // Stage 1: per-segment leading-run analysis
    // ------------------------------------------------------------------
    logic [MODE_W-1:0] w_mode_c;
    logic [31:0]       w_s1_mask;     // segments per lane minus one
    logic [NL*CW-1:0]  w_cnt;
    logic [NL-1:0]     w_first;
    logic [NL-1:0]     w_alleq;

    assign w_mode_c  = (in_mode > c_MAX_MODE) ? c_MAX_MODE : in_mode;
    assign w_s1_mask = (32'd1 << w_mode_c) - 32'd1;

    for (genvar s = 0; s < NL; s++) begin : g_seg
        logic [MIN_LANE-1:0] w_seg;
        logic                w_top;
        logic                w_tb;
        logic                w_run_on;
        logic [CW-1:0]       w_c;

        assign w_seg = in_data[s*MIN_LANE +: MIN_LANE];
        // A lane-top segment carries the sign bit, which is not part of the run
        assign w_top = ((32'(s) & w_s1_mask) == w_s1_mask);

        // Count bits equal to the first analysed bit, walking down from the top
        always_comb begin
            w_tb     = w_top ? w_seg[MIN_LANE-2] : w_seg[MIN_LANE-1];
            w_c      = '0;
            w_run_on = 1'b1;
            for (int b = MIN_LANE - 1; b >= 0; b--) begin
                if (!(w_top && (b == MIN_LANE - 1))) begin
                    if (w_run_on && (w_seg[b] == w_tb)) begin
                        w_c = w_c + CW'(1);
                    end else begin
                        w_run_on = 1'b0;
                    end
                end
            end
        end

        assign w_cnt[s*CW +: CW] = w_c;
        assign w_first[s]        = w_tb;
        assign w_alleq[s]        = w_run_on;
    end

    logic [NL*CW-1:0]  r_s1_cnt;
    logic [NL-1:0]     r_s1_first;
    logic [NL-1:0]     r_s1_alleq;
    logic [MODE_W-1:0] r_s1_mode;

    // Stage 1 register: capture segment summaries on input transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cnt   <= '0;
            r_s1_first <= '0;
            r_s1_alleq <= '0;
            r_s1_mode  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_cnt   <= w_cnt;
                r_s1_first <= w_first;
                r_s1_alleq <= w_alleq;
                r_s1_mode  <= w_mode_c;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: merge segments top-down within each lane
    // ------------------------------------------------------------------
    logic [31:0]      w_s2_mask;
    logic [31:0]      w_s2_lanesz;
    logic [31:0]      w_s2_runmax;   // L-1 for the beat's lane width
    logic [NL*CW-1:0] w_run;
    logic [NL-1:0]    w_rbit;
    logic [NL-1:0]    w_term;
    logic [CW-1:0]    w_acc;
    logic             w_rb;
    logic             w_go;

    assign w_s2_mask   = (32'd1 << r_s1_mode) - 32'd1;
    assign w_s2_lanesz = w_s2_mask + 32'd1;
    assign w_s2_runmax = (32'(MIN_LANE) << r_s1_mode) - 32'd1;

    // A lower segment contributes only while every segment above it in the
    // lane is a full run of the regime bit
    always_comb begin
        w_run  = '0;
        w_rbit = '0;
        w_term = '0;
        w_acc  = '0;
        w_rb   = 1'b0;
        w_go   = 1'b0;
        for (int k = 0; k < NL; k++) begin
            if ((32'(k) & w_s2_mask) == w_s2_mask) begin
                w_rb  = r_s1_first[k];
                w_acc = '0;
                w_go  = 1'b1;
                for (int i = NL - 1; i >= 0; i--) begin
                    if ((i <= k) && ((32'(i) + w_s2_lanesz) > 32'(k))) begin
                        if (w_go && (r_s1_first[i] == w_rb)) begin
                            w_acc = w_acc + r_s1_cnt[i*CW +: CW];
                        end
                        w_go = w_go && r_s1_alleq[i] && (r_s1_first[i] == w_rb);
                    end
                end
                w_run[k*CW +: CW] = w_acc;
                w_rbit[k]         = w_rb;
                w_term[k]         = (32'(w_acc) == w_s2_runmax);
            end
        end
    end

    // Output register: hold while stalled, load on stage 2 advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_run   <= '0;
            out_rbit  <= '0;
            out_term  <= '0;
            out_mode  <= '0;
        end else if (w_s2_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_run  <= w_run;
                out_rbit <= w_rbit;
                out_term <= w_term;
                out_mode <= r_s1_mode;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_posit_regime_run_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_posit_regime_run_pipe
//  Purpose  : Self-checking bench for posit_regime_run_pipe (W=32, lanes 8+)
//  Revision : 1.0  initial release
// ============================================================================
module tb_posit_regime_run_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_run;
    logic [3:0]  out_rbit;
    logic [3:0]  out_term;
    logic [1:0]  out_mode;

    int errs   = 0;
    int checks = 0;

    posit_regime_run_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_run   (out_run),
        .out_rbit  (out_rbit),
        .out_term  (out_term),
        .out_mode  (out_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  m;
        logic [19:0] run;
        logic [3:0]  rb;
        logic [3:0]  tm;
        logic [1:0]  mo;
    } vec_t;

    typedef struct {
        logic [19:0] run;
        logic [3:0]  rb;
        logic [3:0]  tm;
        logic [1:0]  mo;
    } res_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: walk each lane bit by bit from L-2 downward
    function automatic res_t model(input logic [31:0] d, input logic [1:0] m);
        res_t r;
        int   mo, len, per, slot, cnt;
        logic rb;
        bit   go;
        r.run = '0; r.rb = '0; r.tm = '0;
        mo  = (m > 2'd2) ? 2 : int'(m);
        len = 8 << mo;
        per = len / 8;
        for (int j = 0; j < 32 / len; j++) begin
            rb  = d[j*len + len - 2];
            cnt = 0;
            go  = 1'b1;
            for (int b = len - 2; b >= 0; b--) begin
                if (go && (d[j*len + b] == rb)) cnt++;
                else go = 1'b0;
            end
            slot = j * per + per - 1;
            r.run[slot*5 +: 5] = cnt[4:0];
            r.rb[slot] = rb;
            r.tm[slot] = (cnt == len - 1);
        end
        r.mo = mo[1:0];
        return r;
    endfunction

    task automatic chk_out(input string nm, input res_t e);
        chk({nm, "_run"},  64'(out_run),  64'(e.run));
        chk({nm, "_rbit"}, 64'(out_rbit), 64'(e.rb));
        chk({nm, "_term"}, 64'(out_term), 64'(e.tm));
        chk({nm, "_mode"}, 64'(out_mode), 64'(e.mo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[10];
        res_t e;
        res_t q[$];
        res_t held;
        logic [31:0] bd[5];
        logic [1:0]  bm[5];
        int   sent, got;
        bit   prev_stall;

        vt[0] = '{32'h7FFF_FFFF, 2'd2, 20'hF8000, 4'b1000, 4'b1000, 2'd2};
        vt[1] = '{32'h0000_1000, 2'd2, 20'h90000, 4'b0000, 4'b0000, 2'd2};
        vt[2] = '{32'h6020_7F81, 2'd0, 20'h104E6, 4'b1010, 4'b0010, 2'd0};
        vt[3] = '{32'h7FF0_8000, 2'd1, 20'h581E0, 4'b1000, 4'b0010, 2'd1};
        vt[4] = '{32'h7FF0_8000, 2'd3, 20'h58000, 4'b1000, 4'b0000, 2'd2};
        vt[5] = '{32'h7FF0_8000, 2'd2, 20'h58000, 4'b1000, 4'b0000, 2'd2};
        vt[6] = '{32'h0001_4001, 2'd1, 20'h70020, 4'b0010, 4'b0000, 2'd1};
        vt[7] = '{32'h7F00_0000, 2'd2, 20'h38000, 4'b1000, 4'b0000, 2'd2};
        vt[8] = '{32'hBF00_00FF, 2'd0, 20'h09CE7, 4'b0001, 4'b0111, 2'd0};
        vt[9] = '{32'h8000_0000, 2'd3, 20'hF8000, 4'b0000, 4'b1000, 2'd2};

        // Reset state, checked asynchronously before any clock edge
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_run",   64'(out_run),   64'd0);
        chk("rst_out_flags", 64'({out_rbit, out_term, out_mode}), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors, one beat at a time with the consumer ready
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = vt[v].d; in_mode = vt[v].m;
            @(negedge clk);   // accept edge has passed
            in_valid = 1'b0;
            chk($sformatf("v%0d_lat1", v), 64'(out_valid), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_valid", v), 64'(out_valid), 64'd1);
            e.run = vt[v].run; e.rb = vt[v].rb; e.tm = vt[v].tm; e.mo = vt[v].mo;
            chk_out($sformatf("v%0d", v), e);
        end
        @(negedge clk);

        // Backpressure: 5 random beats, consumer stalled for 4 cycles
        for (int i = 0; i < 5; i++) begin
            bd[i] = $urandom_range(0, 1) ? ($urandom >> $urandom_range(0, 31))
                                         : ~($urandom >> $urandom_range(0, 31));
            bm[i] = 2'($urandom_range(0, 3));
        end
        sent = 0; got = 0; prev_stall = 1'b0;
        held.run = '0; held.rb = '0; held.tm = '0; held.mo = '0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            out_ready = (c >= 4);
            in_valid  = (sent < 5);
            if (sent < 5) begin
                in_data = bd[sent]; in_mode = bm[sent];
            end
            #1;
            if (c == 2 || c == 3) chk($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'd0);
            if (prev_stall) begin
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk_out("bp_hold", held);
            end
            prev_stall = out_valid && !out_ready;
            held.run = out_run; held.rb = out_rbit; held.tm = out_term; held.mo = out_mode;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("bp_unexpected_beat", 64'd1, 64'd0);
                end else begin
                    chk_out($sformatf("bp_beat%0d", got), q.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(bd[sent], bm[sent]));
                sent++;
            end
        end
        chk("bp_count", 64'(got), 64'd5);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Reset with two beats in flight
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h7FFF_FFFF; in_mode = 2'd2;
        @(negedge clk);
        in_data = 32'h0F0F_0F0F; in_mode = 2'd0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_pre_valid", 64'(out_valid), 64'd1);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_run",   64'(out_run),   64'd0);
        chk("mid_rst_flags", 64'({out_rbit, out_term, out_mode}), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h4000_00FF; in_mode = 2'd1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_lat1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("post_valid", 64'(out_valid), 64'd1);
        chk_out("post", model(32'h4000_00FF, 2'd1));
        @(negedge clk);
        chk("post_drained", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/posit_regime_run_pipe.md
# posit_regime_run_pipe

Parametrised, two-stage pipelined regime-run counter for SIMD posit words. It splits a W-bit word into 1, 2, 4, … lanes according to a runtime mode. For each lane it reports the length of the regime run that starts just below the lane's sign bit, the regime bit value, and whether the run reaches the lane LSB. It sits between the operand register and the regime/exponent decoder of the posit FMA datapath, with valid/ready handshakes on both sides.

## Interface
- `W`, default 32: word width; power of two, ≥ MIN_LANE.
- `MIN_LANE`, default 8: narrowest lane width; power of two, ≥ 4.
- `NL` (derived) = W/MIN_LANE: number of result slots.
- `CW` (derived) = $clog2(W): run-count field width.
- `MODE_W` (derived) = $clog2($clog2(NL)+1), minimum 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_data` in W: posit lanes, lane j occupying bits [j·L +: L].
- `in_mode` in MODE_W: lane width L = MIN_LANE << min(in_mode, $clog2(NL)).
- `out_valid` out 1: result beat present.
- `out_ready` in 1: consumer takes the beat.
- `out_run` out NL·CW: slot k in bits [k·CW +: CW].
- `out_rbit` out NL: regime bit per slot.
- `out_term` out NL: run hits lane LSB (no terminating bit).
- `out_mode` out MODE_W: clamped mode of this beat.

## Operation
- Lane semantics: the lane MSB is the sign and is ignored. No two's-complement negation is applied; the caller supplies magnitude-form regimes.
- `run` = number of consecutive bits from bit L-2 downward equal to bit L-2. Range 1..L-1.
- `rbit` = bit L-2.
- `term` = 1 iff run = L-1.
- Result placement: lane j writes slot j·(L/MIN_LANE) + L/MIN_LANE − 1, the lane's top slot. All other slots of the lane read run=0, rbit=0, term=0.
- `in_mode` values above $clog2(NL) are clamped to $clog2(NL) (whole-word mode). `out_mode` returns the clamped value.
- Stage 1, per MIN_LANE segment: compute and register the following.
  - Leading-run count of the segment. The top bit is excluded when that segment is a lane top under the beat's mode.
  - Segment first-bit value.
  - All-equal flag.
  - The clamped mode.
- Stage 2: merge segments top-down within each lane.
  - Count accumulates into the next lower segment only while every higher segment is all-equal and its first bit matches the lane's regime bit.
  - Then write the slot fields.
- Arithmetic: counts are unsigned CW bits. The maximum value W-1 fits, so no overflow is possible.

## Timing
- Latency: 2 cycles. A beat accepted at edge n appears on outputs after edge n+2 when not stalled.
- Throughput: 1 beat per cycle when `out_ready` is held high.
- Handshake rules:
  - Transfer occurs when valid && ready at a rising edge.
  - `out_*` are held stable while `out_valid` && !`out_ready`.
  - `out_valid`, once raised, never drops without a transfer.
- Stage 2 advance: s2_adv = !out_valid | out_ready.
- Stage 1 advance: s1_adv = !s1_valid | s2_adv.
- `in_ready` = s1_adv. It is combinational from `out_ready`; there is no path from `in_valid` to `in_ready`.
- Two beats may be buffered while `out_ready` is low. The next beat is refused (`in_ready`=0) until a transfer occurs.
- Simultaneous input accept and output transfer in one cycle is legal and loses no beat.
- Reset:
  - `rst` asserted at any time immediately clears s1_valid and `out_valid`, and drives `out_run`, `out_rbit`, `out_term` and `out_mode` to 0.
  - In-flight beats are discarded.
  - `in_ready`=1 from the first edge after release.

## Test plan
- W=32, mode 2, `in_data`=32'h7FFF_FFFF -> slot3 run=31, rbit=1, term=1; slots 0-2 all zero; `out_valid` two cycles after accept.
- Mode 2, `in_data`=32'h0000_1000 -> slot3 run=18, rbit=0, term=0.
- Mode 0, `in_data`=32'h6020_7F81 -> runs {slot3..0}={2,1,7,6}, rbit={1,0,1,0}, term={0,0,1,0}.
- Mode 1, `in_data`=32'h7FF0_8000 -> slot3 run=11, rbit=1, term=0; slot1 run=15, rbit=0, term=1; slots 2 and 0 zero.
  - Repeat with mode 3 vs mode 2 on the same data -> identical results, `out_mode`=2.
- Backpressure: stream 5 random beats with `out_ready` low for 4 cycles -> `in_ready` falls after 2 accepts, outputs stay frozen, all 5 results emerge in order with no duplicates; compare against a reference model.
- Reset mid-stream: assert `rst` with 2 beats in flight -> `out_valid`=0 and outputs 0 asynchronously; after release, the first new beat appears 2 cycles after accept with correct values.
